// File: rtl/rx_iq_pkg.sv
// Shared types and constants for the RX IQ interface: capture FSM states,
// gain fixed-point format and output saturation limits.
package rx_iq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } cap_state_e;

    localparam int          GAIN_W         = 10;
    localparam int          GAIN_FRAC_BITS = 7;
    localparam logic [15:0] SAT_MAX        = 16'h7fff;
    localparam logic [15:0] SAT_MIN        = 16'h8000;

endpackage

// File: rtl/rx_iq_fifo.sv
// Synchronous first-word-fall-through FIFO with flush. The head is driven
// combinationally and forced to zero while empty; a full write without a pop drops.
module rx_iq_fifo #(
    parameter int DW = 64,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic          drop
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wp, rp;
    logic          pop, push;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign push  = wr_en && (!full || pop);
    assign drop  = wr_en && full && !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rp[AW-1:0]];

endmodule

// File: rtl/rx_iq_intf.sv
// RX IQ interface: channel select, signed Q3.7 gain with saturation, and a
// triggered capture that packs sample pairs into an FWFT FIFO for the AXIS writer.
module rx_iq_intf
    import rx_iq_pkg::*;
#(
    parameter int IQ_DATA_WIDTH          = 16,
    parameter int ADC_PACK_DATA_WIDTH    = 64,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int FIFO_ADDR_WIDTH        = 9,
    parameter int CAPTURE_LEN_WIDTH      = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [ADC_PACK_DATA_WIDTH-1:0]    adc_iq_pack,
    input  logic                              adc_iq_valid,
    input  logic                              ch_sel,
    input  logic [GAIN_W-1:0]                 rx_gain,
    output logic [IQ_DATA_WIDTH-1:0]          rf_i,
    output logic [IQ_DATA_WIDTH-1:0]          rf_q,
    output logic                              rf_iq_valid,
    input  logic                              capture_start,
    input  logic                              capture_trigger,
    input  logic [CAPTURE_LEN_WIDTH-1:0]      capture_len,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_to_m_axis,
    output logic                              emptyn_to_m_axis,
    input  logic                              ask_data_from_m_axis,
    output logic                              capture_busy,
    output logic                              capture_done,
    output logic                              capture_overflow
);
    localparam int IQ     = IQ_DATA_WIDTH;
    localparam int PW     = IQ + GAIN_W;
    localparam int STAGES = 1;

    // vld_pipe[0]: stage1 (selected sample), vld_pipe[1]: stage2 (gained output)
    logic [STAGES:0]        vld_pipe;
    logic signed [IQ-1:0]   s1_i, s1_q;
    logic signed [PW-1:0]   prod_i, prod_q, gain_ext;

    function automatic logic [IQ-1:0] sat(input logic signed [PW-1:0] p);
        if (p[PW-1:IQ+GAIN_FRAC_BITS-1] == '0 || p[PW-1:IQ+GAIN_FRAC_BITS-1] == '1)
            return p[IQ+GAIN_FRAC_BITS-1:GAIN_FRAC_BITS];
        else
            return p[PW-1] ? SAT_MIN : SAT_MAX;
    endfunction

    assign gain_ext = PW'($signed(rx_gain));
    assign prod_i   = PW'(s1_i) * gain_ext;
    assign prod_q   = PW'(s1_q) * gain_ext;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            s1_i     <= '0;
            s1_q     <= '0;
            rf_i     <= '0;
            rf_q     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], adc_iq_valid};
            if (adc_iq_valid) begin
                s1_i <= ch_sel ? adc_iq_pack[3*IQ-1:2*IQ] : adc_iq_pack[IQ-1:0];
                s1_q <= ch_sel ? adc_iq_pack[4*IQ-1:3*IQ] : adc_iq_pack[2*IQ-1:IQ];
            end
            if (vld_pipe[0]) begin
                rf_i <= sat(prod_i);
                rf_q <= sat(prod_q);
            end
        end
    end

    assign rf_iq_valid = vld_pipe[STAGES];

    cap_state_e                   state, state_nxt;
    logic [CAPTURE_LEN_WIDTH-1:0] len_r, cnt;
    logic                         phase, pack_lat, fifo_wr, fifo_drop, fifo_empty, fifo_full;
    logic [2*IQ-1:0]              smp_a;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pack_lat  = 1'b0;
        fifo_wr   = 1'b0;
        unique case (state)
            IDLE: ;
            ARMED:
                if (capture_trigger)
                    state_nxt = (capture_len == '0) ? DONE : CAPTURE;
            CAPTURE:
                if (rf_iq_valid) begin
                    if (!phase) begin
                        pack_lat = 1'b1;
                    end else begin
                        fifo_wr = 1'b1;
                        if (cnt + 1'b1 == len_r) state_nxt = DONE;
                    end
                end
            DONE: ;
            default: state_nxt = IDLE;
        endcase
        if (capture_start) begin
            state_nxt = ARMED;
            pack_lat  = 1'b0;
            fifo_wr   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_r            <= '0;
            cnt              <= '0;
            phase            <= 1'b0;
            smp_a            <= '0;
            capture_overflow <= 1'b0;
        end else if (capture_start) begin
            cnt              <= '0;
            phase            <= 1'b0;
            capture_overflow <= 1'b0;
        end else begin
            if (state == ARMED && capture_trigger) begin
                len_r <= capture_len;
                cnt   <= '0;
                phase <= 1'b0;
            end
            if (pack_lat) begin
                smp_a <= {rf_q, rf_i};
                phase <= 1'b1;
            end
            // Dropped words still count toward capture_len.
            if (fifo_wr) begin
                phase <= 1'b0;
                cnt   <= cnt + 1'b1;
            end
            if (fifo_drop) capture_overflow <= 1'b1;
        end
    end

    rx_iq_fifo #(
        .DW (C_M00_AXIS_TDATA_WIDTH),
        .AW (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (capture_start),
        .wr_en   (fifo_wr),
        .wr_data ({rf_q, rf_i, smp_a}),
        .rd_en   (ask_data_from_m_axis),
        .rd_data (data_to_m_axis),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .drop    (fifo_drop)
    );

    assign emptyn_to_m_axis = !fifo_empty;
    assign capture_busy     = (state == ARMED) || (state == CAPTURE);
    assign capture_done     = (state == DONE);

endmodule

// File: tb/tb_rx_iq_intf.sv
// Directed and randomized bench for rx_iq_intf with a small FIFO (depth 4);
// expected samples and words come from an arithmetic gain model and a word queue.
module tb_rx_iq_intf;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] adc_iq_pack = '0;
    logic        adc_iq_valid = 1'b0;
    logic        ch_sel = 1'b0;
    logic [9:0]  rx_gain = 10'd128;
    logic [15:0] rf_i, rf_q;
    logic        rf_iq_valid;
    logic        capture_start = 1'b0;
    logic        capture_trigger = 1'b0;
    logic [15:0] capture_len = '0;
    logic [63:0] data_to_m_axis;
    logic        emptyn_to_m_axis;
    logic        ask_data_from_m_axis = 1'b0;
    logic        capture_busy, capture_done, capture_overflow;

    rx_iq_intf #(.FIFO_ADDR_WIDTH(2)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .adc_iq_pack          (adc_iq_pack),
        .adc_iq_valid         (adc_iq_valid),
        .ch_sel               (ch_sel),
        .rx_gain              (rx_gain),
        .rf_i                 (rf_i),
        .rf_q                 (rf_q),
        .rf_iq_valid          (rf_iq_valid),
        .capture_start        (capture_start),
        .capture_trigger      (capture_trigger),
        .capture_len          (capture_len),
        .data_to_m_axis       (data_to_m_axis),
        .emptyn_to_m_axis     (emptyn_to_m_axis),
        .ask_data_from_m_axis (ask_data_from_m_axis),
        .capture_busy         (capture_busy),
        .capture_done         (capture_done),
        .capture_overflow     (capture_overflow)
    );

    always #5 clk = ~clk;

    int          npass = 0;
    int          ntot = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Gain reference: real product scaled by 1/128 (floor), clamped to int16.
    function automatic logic [15:0] ref_gain(input logic [15:0] s, input logic [9:0] g);
        int si, gi, r;
        si = int'($signed(s));
        gi = int'($signed(g));
        r  = (si * gi) >>> 7;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic put(input logic [63:0] p);
        @(negedge clk);
        adc_iq_pack  = p;
        adc_iq_valid = 1'b1;
        @(negedge clk);
        adc_iq_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        capture_start = 1'b1;
        @(negedge clk);
        capture_start = 1'b0;
    endtask

    task automatic pulse_trigger(input logic [15:0] len);
        @(negedge clk);
        capture_trigger = 1'b1;
        capture_len     = len;
        @(negedge clk);
        capture_trigger = 1'b0;
    endtask

    // Arm, trigger and feed nsamp samples; fills exp_q with the words a
    // non-draining FIFO of DEPTH entries must hold afterwards.
    task automatic capture_run(input int len, input int nsamp, input bit ramp);
        logic [31:0] gs[$];
        logic [15:0] si, sq;
        logic [63:0] p;
        exp_q.delete();
        pulse_start();
        pulse_trigger(16'(len));
        for (int n = 0; n < nsamp; n++) begin
            si = ramp ? 16'(n + 1) : 16'($urandom);
            sq = ramp ? 16'(n + 1) : 16'($urandom);
            p  = ch_sel ? {sq, si, 32'($urandom)} : {32'($urandom), sq, si};
            put(p);
            gs.push_back({ref_gain(sq, rx_gain), ref_gain(si, rx_gain)});
        end
        for (int k = 0; k < len && 2 * k + 1 < gs.size(); k++)
            if (exp_q.size() < DEPTH) exp_q.push_back({gs[2*k+1], gs[2*k]});
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        logic [63:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_emptyn"}, 64'(emptyn_to_m_axis), 64'd1);
            chk({tag, "_word"}, data_to_m_axis, e);
            ask_data_from_m_axis = 1'b1;
            @(negedge clk);
            ask_data_from_m_axis = 1'b0;
        end
        chk({tag, "_empty_after"}, 64'(emptyn_to_m_axis), 64'd0);
    endtask

    initial begin
        logic [15:0] ri, rq;
        logic [63:0] p;

        // Reset state
        #2;
        chk("rst_rf_i", 64'(rf_i), 64'd0);
        chk("rst_rf_q", 64'(rf_q), 64'd0);
        chk("rst_valid", 64'(rf_iq_valid), 64'd0);
        chk("rst_emptyn", 64'(emptyn_to_m_axis), 64'd0);
        chk("rst_data", data_to_m_axis, 64'd0);
        chk("rst_busy", 64'(capture_busy), 64'd0);
        chk("rst_done", 64'(capture_done), 64'd0);
        chk("rst_ovf", 64'(capture_overflow), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Trigger in IDLE is ignored
        pulse_trigger(16'd2);
        chk("idle_trig_busy", 64'(capture_busy), 64'd0);
        put(64'h0001_0001_0001_0001);
        put(64'h0002_0002_0002_0002);
        repeat (3) @(negedge clk);
        chk("idle_trig_emptyn", 64'(emptyn_to_m_axis), 64'd0);
        chk("idle_trig_done", 64'(capture_done), 64'd0);

        // Directed gain, channel 1, x2
        ch_sel  = 1'b1;
        rx_gain = 10'd256;
        put({16'hfc18, 16'd1000, 32'h1234_5678});
        chk("gain_valid_early", 64'(rf_iq_valid), 64'd0);
        @(negedge clk);
        chk("gain_valid", 64'(rf_iq_valid), 64'd1);
        chk("gain_i", 64'(rf_i), 64'(16'd2000));
        chk("gain_q", 64'(rf_q), 64'(16'hf830));

        // Saturation both ways, channel 0
        ch_sel  = 1'b0;
        rx_gain = 10'd511;
        put({32'h0, 16'd0, 16'd30000});
        @(negedge clk);
        chk("sat_pos", 64'(rf_i), 64'(16'h7fff));
        put({32'h0, 16'd0, 16'h8ad0});
        @(negedge clk);
        chk("sat_neg", 64'(rf_i), 64'(16'h8000));

        // Randomized gain against the model
        for (int n = 0; n < 8; n++) begin
            ch_sel  = 1'($urandom);
            rx_gain = 10'($urandom);
            p       = {$urandom, $urandom};
            ri = ref_gain(ch_sel ? p[47:32] : p[15:0], rx_gain);
            rq = ref_gain(ch_sel ? p[63:48] : p[31:16], rx_gain);
            put(p);
            @(negedge clk);
            chk("rnd_gain_i", 64'(rf_i), 64'(ri));
            chk("rnd_gain_q", 64'(rf_q), 64'(rq));
        end

        // Ramp capture, len 4, with first-word latency checked
        ch_sel  = 1'b0;
        rx_gain = 10'd128;
        pulse_start();
        chk("arm_busy", 64'(capture_busy), 64'd1);
        pulse_trigger(16'd4);
        put(64'h0000_0000_0001_0001);
        put(64'h0000_0000_0002_0002);
        @(negedge clk);
        chk("lat_not_yet", 64'(emptyn_to_m_axis), 64'd0);
        @(negedge clk);
        chk("lat_first", 64'(emptyn_to_m_axis), 64'd1);
        chk("ramp_word0", data_to_m_axis, 64'h0002_0002_0001_0001);
        for (int n = 3; n <= 8; n++) put({32'h0, 16'(n), 16'(n)});
        repeat (3) @(negedge clk);
        chk("ramp_done", 64'(capture_done), 64'd1);
        chk("ramp_busy", 64'(capture_busy), 64'd0);
        for (int k = 0; k < 4; k++)
            exp_q.push_back({16'(2*k+2), 16'(2*k+2), 16'(2*k+1), 16'(2*k+1)});
        drain("ramp");

        // Ask held while empty: nothing pops, head stays zero
        ask_data_from_m_axis = 1'b1;
        repeat (3) @(negedge clk);
        ask_data_from_m_axis = 1'b0;
        chk("ask_empty_emptyn", 64'(emptyn_to_m_axis), 64'd0);
        chk("ask_empty_data", data_to_m_axis, 64'd0);

        // Overflow: len 6 into a depth-4 FIFO with no reader
        capture_run(6, 12, 1'b1);
        chk("ovf_flag", 64'(capture_overflow), 64'd1);
        chk("ovf_done", 64'(capture_done), 64'd1);
        drain("ovf");
        pulse_start();
        chk("ovf_cleared", 64'(capture_overflow), 64'd0);

        // Randomized captures, with extra samples after the last word
        for (int r = 0; r < 3; r++) begin
            int len;
            len     = int'($urandom_range(1, 4));
            ch_sel  = 1'($urandom);
            rx_gain = 10'($urandom);
            capture_run(len, 2 * len + 3, 1'b0);
            chk("rnd_cap_done", 64'(capture_done), 64'd1);
            chk("rnd_cap_ovf", 64'(capture_overflow), 64'd0);
            drain("rnd_cap");
        end

        // Zero-length trigger goes straight to DONE
        pulse_start();
        pulse_trigger(16'd0);
        chk("len0_done", 64'(capture_done), 64'd1);
        put(64'h0000_0000_0005_0005);
        put(64'h0000_0000_0006_0006);
        repeat (3) @(negedge clk);
        chk("len0_emptyn", 64'(emptyn_to_m_axis), 64'd0);

        // Start while CAPTURE flushes and re-arms
        ch_sel  = 1'b0;
        rx_gain = 10'd128;
        pulse_start();
        pulse_trigger(16'd4);
        put(64'h0000_0000_0001_0001);
        put(64'h0000_0000_0002_0002);
        repeat (2) @(negedge clk);
        chk("mid_has_word", 64'(emptyn_to_m_axis), 64'd1);
        pulse_start();
        chk("mid_flushed", 64'(emptyn_to_m_axis), 64'd0);
        chk("mid_armed", 64'(capture_busy), 64'd1);

        // Start and trigger together: stays ARMED, stores nothing
        @(negedge clk);
        capture_start   = 1'b1;
        capture_trigger = 1'b1;
        capture_len     = 16'd2;
        @(negedge clk);
        capture_start   = 1'b0;
        capture_trigger = 1'b0;
        put(64'h0000_0000_0003_0003);
        put(64'h0000_0000_0004_0004);
        repeat (3) @(negedge clk);
        chk("both_busy", 64'(capture_busy), 64'd1);
        chk("both_emptyn", 64'(emptyn_to_m_axis), 64'd0);

        // Async reset in the middle of a capture
        pulse_trigger(16'd4);
        put(64'h0000_0000_0007_0007);
        put(64'h0000_0000_0008_0008);
        repeat (2) @(negedge clk);
        chk("pre_rst_emptyn", 64'(emptyn_to_m_axis), 64'd1);
        adc_iq_pack  = 64'h0000_0000_0009_0009;
        adc_iq_valid = 1'b1;
        #2 rstn = 1'b0;
        #1;
        adc_iq_valid = 1'b0;
        chk("arst_rf_i", 64'(rf_i), 64'd0);
        chk("arst_rf_q", 64'(rf_q), 64'd0);
        chk("arst_emptyn", 64'(emptyn_to_m_axis), 64'd0);
        chk("arst_data", data_to_m_axis, 64'd0);
        chk("arst_busy", 64'(capture_busy), 64'd0);
        chk("arst_done", 64'(capture_done), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 64'(capture_busy), 64'd0);
        chk("post_rst_done", 64'(capture_done), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
